// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM-stage pipeline register and a word-wide data RAM.
// Sub-word stores use read-modify-write; loads are lane-selected and sign/zero-extended.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_write,
    output logic                  mem_read,
    input  logic [31:0]           mem_rdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACCESS    = 2'd1,
        ST_WRITEBACK = 2'd2,
        ST_RESP      = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  write_q, write_d;
    logic [1:0]            size_q, size_d;
    logic                  signed_q, signed_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           merge_q, merge_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;

    logic accept_s;
    logic misalign_s;

    function automatic logic [1:0] byte_lane(input logic [1:0] a);
        byte_lane = BIG_ENDIAN ? (2'd3 - a) : a;
    endfunction

    function automatic logic half_lane(input logic a1);
        half_lane = BIG_ENDIAN ? ~a1 : a1;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] rdata, input logic [1:0] size,
                                                input logic sgn, input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{byte_lane(a), 3'b000} +: 8];
        h = rdata[{half_lane(a[1]), 4'b0000} +: 16];
        case (size)
            2'd0:    extend_load = {{24{sgn & b[7]}}, b};
            2'd1:    extend_load = {{16{sgn & h[15]}}, h};
            default: extend_load = rdata;
        endcase
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] size, input logic [1:0] a);
        logic [31:0] res;
        res = old;
        case (size)
            2'd0:    res[{byte_lane(a), 3'b000} +: 8] = wd[7:0];
            2'd1:    res[{half_lane(a[1]), 4'b0000} +: 16] = wd[15:0];
            default: res = wd;
        endcase
        merge_store = res;
    endfunction

    assign accept_s   = req_valid && req_ready;
    assign misalign_s = (req_size == 2'd3) ||
                        ((req_size == 2'd1) && req_addr[0]) ||
                        ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latch, merge buffer and held response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            write_q      <= 1'b0;
            size_q       <= 2'd0;
            signed_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'h0000_0000;
            merge_q      <= 32'h0000_0000;
            resp_rdata_q <= 32'h0000_0000;
            resp_err_q   <= 1'b0;
        end else begin
            write_q      <= write_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            merge_q      <= merge_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = misalign_s ? ST_RESP : ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (write_q && (size_q != 2'd2)) begin
                    state_d = ST_WRITEBACK;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_WRITEBACK: state_d = ST_RESP;
            ST_RESP:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Datapath register updates; response registers change only on entry to RESP
    always_comb begin
        write_d      = write_q;
        size_d       = size_q;
        signed_d     = signed_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        merge_d      = merge_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    write_d  = req_write;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (misalign_s) begin
                        resp_rdata_d = 32'h0000_0000;
                        resp_err_d   = 1'b1;
                    end else begin
                        resp_err_d   = resp_err_q;
                    end
                end else begin
                    write_d = write_q;
                end
            end
            ST_ACCESS: begin
                if (!write_q) begin
                    resp_rdata_d = extend_load(mem_rdata, size_q, signed_q, addr_q[1:0]);
                    resp_err_d   = 1'b0;
                end else if (size_q == 2'd2) begin
                    resp_rdata_d = 32'h0000_0000;
                    resp_err_d   = 1'b0;
                end else begin
                    merge_d = mem_rdata;
                end
            end
            ST_WRITEBACK: begin
                resp_rdata_d = 32'h0000_0000;
                resp_err_d   = 1'b0;
            end
            ST_RESP: begin
                merge_d = merge_q;
            end
            default: begin
                merge_d = merge_q;
            end
        endcase
    end

    // Outputs; RAM strobes are gated by reset so an aborted access never writes
    always_comb begin
        mem_addr   = '0;
        mem_wdata  = 32'h0000_0000;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        resp_valid = 1'b0;
        req_ready  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = !reset;
            end
            ST_ACCESS: begin
                mem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                mem_read = !reset;
                if (write_q && (size_q == 2'd2)) begin
                    mem_wdata = wdata_q;
                    mem_write = !reset;
                end else begin
                    mem_write = 1'b0;
                end
            end
            ST_WRITEBACK: begin
                mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                mem_wdata = merge_store(merge_q, wdata_q, size_q, addr_q[1:0]);
                mem_write = !reset;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Table-driven bench for mem_access_unit (little-endian): RAM model, expectation queue
// popped on each resp_valid, plus hand-written reset-abort and back-to-back sequences.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    mem_access_unit #(.ADDR_WIDTH(32), .BIG_ENDIAN(1'b0)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_memcyc;
        int          exp_wr;
    } vec_t;

    typedef struct {
        string       nm;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    vec_t        vecs[$];
    exp_t        exp_q[$];
    int          rc_q[$];
    logic [31:0] ram [0:63] = '{default: 32'h0000_0000};
    int          cyc = 0;
    int          n_wr = 0;
    int          n_mem = 0;
    int          n_acc = 0;
    int          n_vec = 0;
    int          n_bad = 0;

    assign mem_rdata = ram[mem_addr[7:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_write) begin
            ram[mem_addr[7:2]] <= mem_wdata;
            n_wr <= n_wr + 1;
        end
        if (req_valid && req_ready) n_acc <= n_acc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: every response pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (resp_valid) begin
            exp_t e;
            rc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected 0 at cycle %0d", cyc);
            end else begin
                e = exp_q.pop_front();
                chk({e.nm, "/rdata"}, resp_rdata, e.rdata);
                chk({e.nm, "/err"}, {31'd0, resp_err}, {31'd0, e.err});
                chk({e.nm, "/lat"}, cyc - e.acc + 1, e.lat);
            end
        end
        if (mem_read || mem_write) n_mem <= n_mem + 1;
    end

    function automatic vec_t mk(input string nm, input logic wr, input logic [1:0] sz,
                                input logic sg, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] er, input logic ee, input int lat,
                                input int mc, input int nw);
        vec_t v;
        v.nm = nm; v.wr = wr; v.sz = sz; v.sg = sg; v.addr = a; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat; v.exp_memcyc = mc; v.exp_wr = nw;
        return v;
    endfunction

    // Drive one request, wait for acceptance, optionally enqueue its expectation
    task automatic do_req(input vec_t v, input bit track, input bit hold);
        int w;
        exp_t e;
        @(negedge clk);
        req_write = v.wr; req_size = v.sz; req_signed = v.sg;
        req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) chk({v.nm, "/ready_timeout"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        if (track) begin
            e.nm = v.nm; e.rdata = v.exp_rdata; e.err = v.exp_err;
            e.lat = v.exp_lat; e.acc = cyc;
            exp_q.push_back(e);
        end
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) begin
            chk({nm, "/resp_timeout"}, exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        int w0, m0;
        w0 = n_wr;
        m0 = n_mem;
        do_req(v, 1'b1, 1'b0);
        drain(v.nm);
        chk({v.nm, "/ram_writes"}, n_wr - w0, v.exp_wr);
        chk({v.nm, "/ram_cycles"}, n_mem - m0, v.exp_memcyc);
    endtask

    initial begin
        vec_t v;
        int   a0;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

        //          name        wr    sz    sg    addr          wdata         exp_rdata    err  lat mc wr
        vecs.push_back(mk("sw_dead",  1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 1, 1));
        vecs.push_back(mk("lw_dead",  1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 0));
        vecs.push_back(mk("sw_1122",  1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 32'h00000000, 1'b0, 2, 1, 1));
        vecs.push_back(mk("sb_aa",    1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA, 32'h00000000, 1'b0, 3, 2, 1));
        vecs.push_back(mk("lw_merge", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h1122AA44, 1'b0, 2, 1, 0));
        vecs.push_back(mk("sw_80ff",  1'b1, 2'd2, 1'b0, 32'h14, 32'h80FF7F01, 32'h00000000, 1'b0, 2, 1, 1));
        vecs.push_back(mk("lb_s17",   1'b0, 2'd0, 1'b1, 32'h17, 32'h0,        32'hFFFFFF80, 1'b0, 2, 1, 0));
        vecs.push_back(mk("lbu_17",   1'b0, 2'd0, 1'b0, 32'h17, 32'h0,        32'h00000080, 1'b0, 2, 1, 0));
        vecs.push_back(mk("lb_s14",   1'b0, 2'd0, 1'b1, 32'h14, 32'h0,        32'h00000001, 1'b0, 2, 1, 0));
        vecs.push_back(mk("lb_s15",   1'b0, 2'd0, 1'b1, 32'h15, 32'h0,        32'h0000007F, 1'b0, 2, 1, 0));
        vecs.push_back(mk("lbu_16",   1'b0, 2'd0, 1'b0, 32'h16, 32'h0,        32'h000000FF, 1'b0, 2, 1, 0));
        vecs.push_back(mk("lb_s16",   1'b0, 2'd0, 1'b1, 32'h16, 32'h0,        32'hFFFFFFFF, 1'b0, 2, 1, 0));
        vecs.push_back(mk("sw_8001",  1'b1, 2'd2, 1'b0, 32'h18, 32'h8001FFFF, 32'h00000000, 1'b0, 2, 1, 1));
        vecs.push_back(mk("lh_s1a",   1'b0, 2'd1, 1'b1, 32'h1A, 32'h0,        32'hFFFF8001, 1'b0, 2, 1, 0));
        vecs.push_back(mk("lhu_1a",   1'b0, 2'd1, 1'b0, 32'h1A, 32'h0,        32'h00008001, 1'b0, 2, 1, 0));
        vecs.push_back(mk("lh_s18",   1'b0, 2'd1, 1'b1, 32'h18, 32'h0,        32'hFFFFFFFF, 1'b0, 2, 1, 0));
        vecs.push_back(mk("lhu_18",   1'b0, 2'd1, 1'b0, 32'h18, 32'h0,        32'h0000FFFF, 1'b0, 2, 1, 0));
        vecs.push_back(mk("lh_mis19", 1'b0, 2'd1, 1'b1, 32'h19, 32'h0,        32'h00000000, 1'b1, 1, 0, 0));
        vecs.push_back(mk("lw_mis12", 1'b0, 2'd2, 1'b0, 32'h12, 32'h0,        32'h00000000, 1'b1, 1, 0, 0));
        vecs.push_back(mk("ld_sz3",   1'b0, 2'd3, 1'b0, 32'h10, 32'h0,        32'h00000000, 1'b1, 1, 0, 0));
        vecs.push_back(mk("st_sz3",   1'b1, 2'd3, 1'b0, 32'h10, 32'h0BADF00D, 32'h00000000, 1'b1, 1, 0, 0));
        vecs.push_back(mk("lw_sgn14", 1'b0, 2'd2, 1'b1, 32'h14, 32'h0,        32'h80FF7F01, 1'b0, 2, 1, 0));
        vecs.push_back(mk("sh_beef",  1'b1, 2'd1, 1'b0, 32'h1A, 32'hFFFFBEEF, 32'h00000000, 1'b0, 3, 2, 1));
        vecs.push_back(mk("lw_18",    1'b0, 2'd2, 1'b0, 32'h18, 32'h0,        32'hBEEFFFFF, 1'b0, 2, 1, 0));
        vecs.push_back(mk("sb_78",    1'b1, 2'd0, 1'b0, 32'h14, 32'h12345678, 32'h00000000, 1'b0, 3, 2, 1));
        vecs.push_back(mk("lw_14",    1'b0, 2'd2, 1'b0, 32'h14, 32'h0,        32'h80FF7F78, 1'b0, 2, 1, 0));
        vecs.push_back(mk("lw_10b",   1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h1122AA44, 1'b0, 2, 1, 0));
        vecs.push_back(mk("sw_5566",  1'b1, 2'd2, 1'b0, 32'h20, 32'h55667788, 32'h00000000, 1'b0, 2, 1, 1));

        // Reset state
        repeat (3) @(negedge clk);
        chk("ready_in_reset", {31'd0, req_ready}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Reset while in WRITEBACK aborts silently with no RAM write
        v = mk("abort_sb", 1'b1, 2'd0, 1'b0, 32'h20, 32'h00000000, 32'h0, 1'b0, 3, 2, 1);
        a0 = n_wr;
        do_req(v, 1'b0, 1'b0);
        @(negedge clk);
        chk("wb_write_before_reset", {31'd0, mem_write}, 32'd1);
        reset = 1'b1;
        #1;
        chk("wb_write_in_reset", {31'd0, mem_write}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ready_after_abort", {31'd0, req_ready}, 32'd1);
        chk("ram_after_abort", ram[8], 32'h55667788);
        chk("writes_after_abort", n_wr - a0, 0);
        repeat (4) @(negedge clk);
        run_vec(mk("lw_20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h55667788, 1'b0, 2, 1, 0));

        // req_valid held high across three back-to-back loads
        rc_q.delete();
        a0 = n_acc;
        do_req(mk("b2b_0", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h1122AA44, 1'b0, 2, 1, 0), 1'b1, 1'b1);
        do_req(mk("b2b_1", 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 32'h80FF7F78, 1'b0, 2, 1, 0), 1'b1, 1'b1);
        do_req(mk("b2b_2", 1'b0, 2'd0, 1'b1, 32'h1B, 32'h0, 32'hFFFFFFBE, 1'b0, 2, 1, 0), 1'b1, 1'b1);
        req_valid = 1'b0;
        drain("b2b");
        chk("b2b_accepts", n_acc - a0, 3);
        chk("b2b_pulses", rc_q.size(), 3);
        if (rc_q.size() == 3) begin
            chk("b2b_gap01", rc_q[1] - rc_q[0], 3);
            chk("b2b_gap12", rc_q[2] - rc_q[1], 3);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
